// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in, serial-out shift transmitter.
// Captures a WIDTH-bit word on an accepted start request, then emits it
// MSB-first, one bit per clock with sout_valid, followed by a one-cycle
// done pulse. Drives the serial input of a left-shift receiver chain.
// Optional feature: define PISO_SHIFT_TX_PARITY_EN to append an even-parity
// bit (XOR of the captured word) after the last data bit.
module piso_shift_tx #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  shreg_reg, shreg_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
`ifdef PISO_SHIFT_TX_PARITY_EN
  logic              par_reg, par_next;
`endif

  // State, shift register and bit counter; clr aborts any word in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // Next-state and datapath update: capture in IDLE, shift left in SHIFT.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
`ifdef PISO_SHIFT_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          shreg_next = din;
          cnt_next   = '0;
`ifdef PISO_SHIFT_TX_PARITY_EN
          // Parity is frozen at acceptance so later din changes cannot leak in.
          par_next   = ^din;
`endif
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
        if (cnt_reg == LAST_CNT) begin
          // Counter parks at its last value instead of wrapping; the next
          // acceptance reloads it.
`ifdef PISO_SHIFT_TX_PARITY_EN
          state_next = PAR;
`else
          state_next = DONE;
`endif
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef PISO_SHIFT_TX_PARITY_EN
      PAR: begin
        state_next = DONE;
      end
`endif
      DONE: begin
        // Start requests seen here are dropped, never queued.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state; no path from start/din.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
      end
      SHIFT: begin
        sout       = shreg_reg[WIDTH-1];
        sout_valid = 1'b1;
        busy       = 1'b1;
      end
`ifdef PISO_SHIFT_TX_PARITY_EN
      PAR: begin
        sout       = par_reg;
        sout_valid = 1'b1;
        busy       = 1'b1;
      end
`endif
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx: directed words, scoreboard of expected
// serial bits / done pulses, and a monitor that checks them at negedge.
module tb_piso_shift_tx;
  localparam int W = 6;
`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic         sout, sout_valid, busy, done, ready;

  piso_shift_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .din        (din),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream left-shift receiver sampling sout on every edge.
  logic [W-1:0] rx = '0;
  always @(posedge clk) rx <= {rx[W-2:0], sout};

  typedef struct {
    int    cyc;
    bit    is_done;
    bit    val;
    string tag;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // Expected response for a word accepted at edge k (cyc==k after that edge).
  task automatic push_word(input logic [W-1:0] w, input int k, input string tag);
    for (int i = 0; i < W; i++) sb.push_back('{k + i, 1'b0, w[W-1-i], tag});
    if (PE != 0) sb.push_back('{k + W, 1'b0, ^w, tag});
    sb.push_back('{k + W + PE, 1'b1, 1'b0, tag});
    $display("tx %s word=%b accepted cyc=%0d", tag, w, k);
  endtask

  // Raise start with word w for one edge from idle; returns acceptance cycle.
  task automatic accept(input logic [W-1:0] w, output int k);
    @(posedge clk); #1;
    start = 1'b1;
    din   = w;
    @(posedge clk); #1;
    k     = cyc;
    start = 1'b0;
    din   = ~w;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bit or done.
  always @(negedge clk) begin
    if (clr === 1'b0) begin
      chk("busy_rel", busy, sout_valid | done);
      chk("ready_rel", ready, !busy);
      if (!sout_valid) chk("sout_idle0", sout, 1'b0);
      if (sout_valid || done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=valid%b_done%b required=none cyc=%0d",
                   sout_valid, done, cyc);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_cyc"}, cyc, e.cyc);
          chk({e.tag, "_kind"}, done, e.is_done);
          if (!e.is_done) chk({e.tag, "_bit"}, sout, e.val);
        end
      end
    end
  end

  int k, k2;

  initial begin
    // Asynchronous reset before any clock edge.
    #2 clr = 1'b1;
    #1;
    chk("rst_sout", sout, 1'b0);
    chk("rst_valid", sout_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", ready, 1'b1);
    #9 clr = 1'b0;

    // Single word with receiver check.
    accept(6'b101101, k);
    push_word(6'b101101, k, "single");
    repeat (W) @(posedge clk);
    #1;
    chk("rx_word", rx, 6'b101101);
    repeat (PE) @(posedge clk);
    #1;
    chk("ready_in_done", ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_after", ready, 1'b1);

    // Start pulses while busy and during DONE are ignored.
    accept(6'b110000, k);
    push_word(6'b110000, k, "busy");
    repeat (2) @(posedge clk);
    #1 start = 1'b1; din = 6'b001111;
    @(posedge clk); #1 start = 1'b0;
    repeat (W + PE - 3) @(posedge clk);
    #1 start = 1'b1; din = 6'b001111;
    @(posedge clk); #1 start = 1'b0;
    repeat (W + 4) @(posedge clk);

    // Back-to-back with start held high: 2-cycle valid gap between words.
    @(posedge clk); #1;
    start = 1'b1;
    din   = 6'b100001;
    @(posedge clk); #1;
    k  = cyc;
    din = 6'b011110;
    k2 = k + W + 2 + PE;
    push_word(6'b100001, k, "b2b0");
    push_word(6'b011110, k2, "b2b1");
    repeat (W + 2 + PE) @(posedge clk);
    #1 start = 1'b0;
    din = 6'b000000;
    repeat (W + 4) @(posedge clk);

    // Reset mid-shift aborts the word immediately; no done afterwards.
    accept(6'b111000, k);
    push_word(6'b111000, k, "abort");
    repeat (2) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    sb.delete();
    $display("tx abort reset asserted cyc=%0d", cyc);
    chk("mid_rst_sout", sout, 1'b0);
    chk("mid_rst_valid", sout_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ready", ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    repeat (W + 4) @(posedge clk);
    accept(6'b010011, k);
    push_word(6'b010011, k, "post_rst");
    repeat (W + PE + 4) @(posedge clk);

`ifdef PISO_SHIFT_TX_PARITY_EN
    // Parity bit follows the data bits.
    accept(6'b101100, k);
    push_word(6'b101100, k, "par1");
    repeat (W) @(posedge clk);
    #1 chk("par1_const", sout, 1'b1);
    repeat (4) @(posedge clk);
    accept(6'b000000, k);
    push_word(6'b000000, k, "par0");
    repeat (W) @(posedge clk);
    #1 chk("par0_const", sout, 1'b0);
    repeat (4) @(posedge clk);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
